multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle successor of the single-cycle/pipelined MIPS control decoder.
- Moore FSM that sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared datapath: one ALU, one unified memory, IR/MDR/ALUOut registers.
- Supports the same instruction set as the current decoder: R-type, jr, addi, ori, andi, lui, lw, sw, beq, bne, j, jal.
- Adds a parametrised memory latency and a per-instruction completion pulse.

Parameters:
- ALUOP_WIDTH, 4, width of alu_op; encodings below must fit.
- MEM_LATENCY, 1, cycles each memory access occupies (legal 1..15). Applies to FETCH, MEM_RD and MEM_WR.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- OP  in  6  opcode, IR[31:26], valid from DECODE onward.
- FUNCT  in  6  function field, IR[5:0].
- zero  in  1  ALU zero flag.
- pc_en  out  1  PC load enable.
- pc_src  out  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target, 3=register rs.
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  2  write register: 0=rt, 1=rd, 2=$31.
- mem_to_reg  out  2  write data: 0=ALUOut, 1=MDR, 2=PC.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU operand A: 0=PC, 1=rs.
- alu_src_b  out  2  ALU operand B: 0=rt, 1=const 4, 2=sign/zero-ext imm, 3=sign-ext imm<<2.
- alu_op  out  ALUOP_WIDTH  ALU operation code.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  unknown opcode flag (see Optional Feature).

Behaviour:
- ALUOp codes: R=15, ADDI=1, ORI=2, ANDI=3, LUI=4, SW=5, LW=6, BEQ=7, BNE=8, J=9, JAL=10. ADD (PC arithmetic) uses code 1.
- Outputs are decoded from state only (Moore). Exception: pc_en in BRANCH also depends on zero.
- Any output not listed for a state is 0.
- Reset (reset=0 sampled at a rising edge):
  - State goes to FETCH; latency counter goes to 0.
  - All outputs read 0 during the reset cycle.
  - Reset mid-instruction abandons that instruction. No write strobe is asserted after the reset edge.
- Latency counter: loads 0 on entry to a memory state and increments each cycle. The state exits when count == MEM_LATENCY-1.
- FETCH (MEM_LATENCY cycles):
  - Every cycle: mem_read=1, i_or_d=0.
  - Final cycle only: ir_write=1, alu_src_a=0, alu_src_b=1, alu_op=1, pc_src=0, pc_en=1.
  - Next state: DECODE.
- DECODE (1 cycle):
  - alu_src_a=0, alu_src_b=3, alu_op=1 (branch target into ALUOut).
  - Dispatch on OP:
    - R-type with FUNCT=0x08 goes to JR.
    - Other R-type goes to EXEC_R.
    - addi/ori/andi/lui go to EXEC_I.
    - lw/sw go to MEM_ADDR.
    - beq/bne go to BRANCH.
    - j/jal go to JUMP.
    - Any other opcode goes to FETCH with instr_done=1.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=15; next WB_R.
- WB_R: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1; next FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op per opcode; next WB_I.
- WB_I: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1; next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=6 (lw) or 5 (sw); next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD (MEM_LATENCY cycles): mem_read=1, i_or_d=1; next MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1; next FETCH.
- MEM_WR (MEM_LATENCY cycles):
  - mem_write=1 and i_or_d=1 every cycle.
  - instr_done=1 on the final cycle.
  - Next FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=7/8, pc_src=1, instr_done=1.
  - pc_en = zero for beq, ~zero for bne.
  - Next FETCH.
- JUMP:
  - pc_src=2, pc_en=1, instr_done=1.
  - For jal also: reg_dst=2, mem_to_reg=2, reg_write=1. PC is already PC+4, so $31 receives the return address.
  - Next FETCH.
- JR: pc_src=3, pc_en=1, instr_done=1; next FETCH.
- OP and FUNCT are used in DECODE and later states. The IR holds them stable until the next FETCH final cycle.
- CPI with L=MEM_LATENCY:
  - R-type and I-type: L+3.
  - lw: 2L+3.
  - sw: 2L+2.
  - beq, bne, j, jal, jr: L+2.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to the TRAP state; illegal_op=1.
  - TRAP is sticky: all other outputs stay 0 and no instr_done.
  - Only reset leaves TRAP.
- Undefined:
  - An unknown opcode acts as a NOP: DECODE goes to FETCH with instr_done=1.
  - illegal_op is tied to 0 and the TRAP state is absent.

Test Plan:
- Reset held 3 cycles, then released, MEM_LATENCY=1 -> first cycle shows FETCH: mem_read=1, ir_write=1, pc_en=1, alu_src_b=1, alu_op=1. All outputs were 0 during reset.
- add (OP=0, FUNCT=0x20), MEM_LATENCY=1 -> instr_done 4 cycles after the FETCH start. WB_R shows reg_dst=1, reg_write=1, alu_op=15 in the preceding cycle.
- lw (OP=0x23), MEM_LATENCY=3 -> mem_read in FETCH for 3 cycles and in MEM_RD for 3 cycles. instr_done on cycle 9 with mem_to_reg=1, reg_write=1.
- beq (OP=0x04) with zero=1, then with zero=0 -> pc_en=1, pc_src=1 in BRANCH; then pc_en=0. Both take 3 cycles at L=1. Repeat for bne with inverted pc_en.
- jal (OP=0x03) -> JUMP shows pc_src=2, pc_en=1, reg_dst=2, mem_to_reg=2, reg_write=1. jr (OP=0, FUNCT=0x08) -> pc_src=3, pc_en=1, reg_write=0.
- OP=0x3F:
  - With MULTICYCLE_ILLEGAL_TRAP_EN: illegal_op=1 held for 20 cycles, no pc_en; reset returns to FETCH.
  - Without: instr_done in DECODE, next cycle is FETCH.
- sw with reset asserted in the second MEM_WR cycle (L=3) -> mem_write=0 from the reset edge; FETCH follows the release.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control sequencer for a multi-cycle MIPS datapath (shared ALU, unified memory).
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module multicycle_control #(
   parameter int ALUOP_WIDTH = 4,
   parameter int MEM_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             OP,
   input  logic [5:0]             FUNCT,
   input  logic                   zero,
   output logic                   pc_en,
   output logic [1:0]             pc_src,
   output logic                   i_or_d,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   ir_write,
   output logic [1:0]             reg_dst,
   output logic [1:0]             mem_to_reg,
   output logic                   reg_write,
   output logic                   alu_src_a,
   output logic [1:0]             alu_src_b,
   output logic [ALUOP_WIDTH-1:0] alu_op,
   output logic                   instr_done,
   output logic                   illegal_op
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = ALUOP_WIDTH'(1);
   localparam logic [ALUOP_WIDTH-1:0] ALU_ORI  = ALUOP_WIDTH'(2);
   localparam logic [ALUOP_WIDTH-1:0] ALU_ANDI = ALUOP_WIDTH'(3);
   localparam logic [ALUOP_WIDTH-1:0] ALU_LUI  = ALUOP_WIDTH'(4);
   localparam logic [ALUOP_WIDTH-1:0] ALU_SW   = ALUOP_WIDTH'(5);
   localparam logic [ALUOP_WIDTH-1:0] ALU_LW   = ALUOP_WIDTH'(6);
   localparam logic [ALUOP_WIDTH-1:0] ALU_BEQ  = ALUOP_WIDTH'(7);
   localparam logic [ALUOP_WIDTH-1:0] ALU_BNE  = ALUOP_WIDTH'(8);
   localparam logic [ALUOP_WIDTH-1:0] ALU_R    = ALUOP_WIDTH'(15);

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
      BRANCH, JUMP, JR
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      , TRAP
`endif
   } state_t;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
   localparam state_t UNKNOWN_TARGET = TRAP;
`else
   localparam state_t UNKNOWN_TARGET = FETCH;
`endif

   state_t     state;
   state_t     decodeTarget;
   logic       knownOp;
   logic [3:0] memCnt;
   logic       memLast;

   assign memLast = (memCnt == 4'(MEM_LATENCY - 1));

   always_comb begin
      knownOp      = 1'b1;
      decodeTarget = FETCH;
      case (OP)
         OP_RTYPE:                         decodeTarget = (FUNCT == FN_JR) ? JR : EXEC_R;
         OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: decodeTarget = EXEC_I;
         OP_LW, OP_SW:                     decodeTarget = MEM_ADDR;
         OP_BEQ, OP_BNE:                   decodeTarget = BRANCH;
         OP_J, OP_JAL:                     decodeTarget = JUMP;
         default:                          knownOp = 1'b0;
      endcase
      if (!knownOp) decodeTarget = UNKNOWN_TARGET;
   end

   // memCnt restarts on every state change, so it counts cycles spent in the current memory state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= FETCH;
         memCnt <= '0;
      end else begin
         memCnt <= '0;
         case (state)
            FETCH:    if (memLast) state <= DECODE; else memCnt <= memCnt + 4'd1;
            DECODE:   state <= decodeTarget;
            EXEC_R:   state <= WB_R;
            EXEC_I:   state <= WB_I;
            MEM_ADDR: state <= (OP == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (memLast) state <= MEM_WB; else memCnt <= memCnt + 4'd1;
            MEM_WR:   if (memLast) state <= FETCH;  else memCnt <= memCnt + 4'd1;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            TRAP:     state <= TRAP;
`endif
            default:  state <= FETCH;
         endcase
      end
   end

   // Outputs are gated by the reset pin so nothing is strobed while reset is held.
   always_comb begin
      pc_en      = 1'b0;
      pc_src     = 2'd0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = '0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      if (reset) begin
         case (state)
            FETCH: begin
               mem_read = 1'b1;
               if (memLast) begin
                  ir_write  = 1'b1;
                  alu_src_b = 2'd1;
                  alu_op    = ALU_ADD;
                  pc_en     = 1'b1;
               end
            end
            DECODE: begin
               alu_src_b = 2'd3;
               alu_op    = ALU_ADD;
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
               instr_done = ~knownOp;
`endif
            end
            EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_R;
            end
            WB_R: begin
               reg_dst    = 2'd1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
               case (OP)
                  OP_ORI:  alu_op = ALU_ORI;
                  OP_ANDI: alu_op = ALU_ANDI;
                  OP_LUI:  alu_op = ALU_LUI;
                  default: alu_op = ALU_ADD;
               endcase
            end
            WB_I: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
               alu_op    = (OP == OP_LW) ? ALU_LW : ALU_SW;
            end
            MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            MEM_WB: begin
               mem_to_reg = 2'd1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            MEM_WR: begin
               mem_write  = 1'b1;
               i_or_d     = 1'b1;
               instr_done = memLast;
            end
            BRANCH: begin
               alu_src_a  = 1'b1;
               alu_op     = (OP == OP_BEQ) ? ALU_BEQ : ALU_BNE;
               pc_src     = 2'd1;
               pc_en      = (OP == OP_BEQ) ? zero : ~zero;
               instr_done = 1'b1;
            end
            JUMP: begin
               pc_src     = 2'd2;
               pc_en      = 1'b1;
               instr_done = 1'b1;
               if (OP == OP_JAL) begin
                  reg_dst    = 2'd2;
                  mem_to_reg = 2'd2;
                  reg_write  = 1'b1;
               end
            end
            JR: begin
               pc_src     = 2'd3;
               pc_en      = 1'b1;
               instr_done = 1'b1;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            TRAP:    illegal_op = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: two instances (latency 1 and 3),
// each compared cycle by cycle against a per-instruction reference sequence.
module tb_multicycle_control;

   typedef struct packed {
      logic       pcEn;
      logic [1:0] pcSrc;
      logic       iOrD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic [1:0] regDst;
      logic [1:0] memToReg;
      logic       regWrite;
      logic       srcA;
      logic [1:0] srcB;
      logic [3:0] aluOp;
      logic       done;
      logic       illegal;
   } ctl_t;

   localparam int W         = 21;
   localparam int LAT0      = 1;
   localparam int LAT1      = 3;
   localparam int TRAP_HOLD = 20;
   localparam int CL_R = 0, CL_JR = 1, CL_I = 2, CL_LW = 3, CL_SW = 4, CL_BR = 5, CL_J = 6, CL_BAD = 7;

   // {op, funct, zero}
   localparam logic [12:0] DIRECTED [16] = '{
      {6'h00, 6'h20, 1'b0}, {6'h23, 6'h00, 1'b0}, {6'h2B, 6'h00, 1'b0}, {6'h04, 6'h00, 1'b1},
      {6'h04, 6'h00, 1'b0}, {6'h05, 6'h00, 1'b1}, {6'h05, 6'h00, 1'b0}, {6'h03, 6'h00, 1'b0},
      {6'h02, 6'h00, 1'b1}, {6'h00, 6'h08, 1'b0}, {6'h08, 6'h00, 1'b0}, {6'h0D, 6'h00, 1'b0},
      {6'h0C, 6'h00, 1'b0}, {6'h0F, 6'h00, 1'b0}, {6'h00, 6'h22, 1'b1}, {6'h3F, 6'h00, 1'b0}
   };

   logic clk;
   int   tests;
   int   failed;
   int   cyc;

   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   ctl_t         seqQ[$];

   // instance 0 (latency 1)
   logic       rst0, zero0;
   logic [5:0] op0, funct0;
   logic       pcEn0, iOrD0, memRead0, memWrite0, irWrite0, regWrite0, srcA0, done0, illegal0;
   logic [1:0] pcSrc0, regDst0, memToReg0, srcB0;
   logic [3:0] aluOp0;
   // instance 1 (latency 3)
   logic       rst1, zero1;
   logic [5:0] op1, funct1;
   logic       pcEn1, iOrD1, memRead1, memWrite1, irWrite1, regWrite1, srcA1, done1, illegal1;
   logic [1:0] pcSrc1, regDst1, memToReg1, srcB1;
   logic [3:0] aluOp1;

   wire [W-1:0] obs0 = {pcEn0, pcSrc0, iOrD0, memRead0, memWrite0, irWrite0, regDst0, memToReg0,
                        regWrite0, srcA0, srcB0, aluOp0, done0, illegal0};
   wire [W-1:0] obs1 = {pcEn1, pcSrc1, iOrD1, memRead1, memWrite1, irWrite1, regDst1, memToReg1,
                        regWrite1, srcA1, srcB1, aluOp1, done1, illegal1};

   multicycle_control #(.ALUOP_WIDTH(4), .MEM_LATENCY(LAT0)) dut0 (
      .clk(clk), .reset(rst0), .OP(op0), .FUNCT(funct0), .zero(zero0),
      .pc_en(pcEn0), .pc_src(pcSrc0), .i_or_d(iOrD0), .mem_read(memRead0),
      .mem_write(memWrite0), .ir_write(irWrite0), .reg_dst(regDst0), .mem_to_reg(memToReg0),
      .reg_write(regWrite0), .alu_src_a(srcA0), .alu_src_b(srcB0), .alu_op(aluOp0),
      .instr_done(done0), .illegal_op(illegal0)
   );

   multicycle_control #(.ALUOP_WIDTH(4), .MEM_LATENCY(LAT1)) dut1 (
      .clk(clk), .reset(rst1), .OP(op1), .FUNCT(funct1), .zero(zero1),
      .pc_en(pcEn1), .pc_src(pcSrc1), .i_or_d(iOrD1), .mem_read(memRead1),
      .mem_write(memWrite1), .ir_write(irWrite1), .reg_dst(regDst1), .mem_to_reg(memToReg1),
      .reg_write(regWrite1), .alu_src_a(srcA1), .alu_src_b(srcB1), .alu_op(aluOp1),
      .instr_done(done1), .illegal_op(illegal1)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int classOf(input logic [5:0] op, input logic [5:0] funct);
      case (op)
         6'h00:                      return (funct == 6'h08) ? CL_JR : CL_R;
         6'h08, 6'h0C, 6'h0D, 6'h0F: return CL_I;
         6'h23:                      return CL_LW;
         6'h2B:                      return CL_SW;
         6'h04, 6'h05:               return CL_BR;
         6'h02, 6'h03:               return CL_J;
         default:                    return CL_BAD;
      endcase
   endfunction

   function automatic logic [3:0] immAluOp(input logic [5:0] op);
      case (op)
         6'h0D:   return 4'd2;
         6'h0C:   return 4'd3;
         6'h0F:   return 4'd4;
         default: return 4'd1;
      endcase
   endfunction

   // Expected control vector for every cycle of one instruction, FETCH first.
   task automatic build_seq(input int lat, input logic [5:0] op, input logic [5:0] funct,
                            input logic z);
      ctl_t c;
      int   cl;
      cl = classOf(op, funct);
      seqQ.delete();
      for (int i = 0; i < lat; i++) begin
         c = '0;
         c.memRead = 1'b1;
         if (i == lat - 1) begin
            c.irWrite = 1'b1; c.srcB = 2'd1; c.aluOp = 4'd1; c.pcEn = 1'b1;
         end
         seqQ.push_back(c);
      end
      c = '0;
      c.srcB = 2'd3; c.aluOp = 4'd1;
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
      if (cl == CL_BAD) c.done = 1'b1;
`endif
      seqQ.push_back(c);
      case (cl)
         CL_R: begin
            c = '0; c.srcA = 1'b1; c.aluOp = 4'd15; seqQ.push_back(c);
            c = '0; c.regDst = 2'd1; c.regWrite = 1'b1; c.done = 1'b1; seqQ.push_back(c);
         end
         CL_I: begin
            c = '0; c.srcA = 1'b1; c.srcB = 2'd2; c.aluOp = immAluOp(op); seqQ.push_back(c);
            c = '0; c.regWrite = 1'b1; c.done = 1'b1; seqQ.push_back(c);
         end
         CL_LW: begin
            c = '0; c.srcA = 1'b1; c.srcB = 2'd2; c.aluOp = 4'd6; seqQ.push_back(c);
            for (int i = 0; i < lat; i++) begin
               c = '0; c.memRead = 1'b1; c.iOrD = 1'b1; seqQ.push_back(c);
            end
            c = '0; c.memToReg = 2'd1; c.regWrite = 1'b1; c.done = 1'b1; seqQ.push_back(c);
         end
         CL_SW: begin
            c = '0; c.srcA = 1'b1; c.srcB = 2'd2; c.aluOp = 4'd5; seqQ.push_back(c);
            for (int i = 0; i < lat; i++) begin
               c = '0; c.memWrite = 1'b1; c.iOrD = 1'b1; c.done = (i == lat - 1);
               seqQ.push_back(c);
            end
         end
         CL_BR: begin
            c = '0; c.srcA = 1'b1; c.pcSrc = 2'd1; c.done = 1'b1;
            c.aluOp = (op == 6'h04) ? 4'd7 : 4'd8;
            c.pcEn  = (op == 6'h04) ? z : ~z;
            seqQ.push_back(c);
         end
         CL_J: begin
            c = '0; c.pcSrc = 2'd2; c.pcEn = 1'b1; c.done = 1'b1;
            if (op == 6'h03) begin
               c.regDst = 2'd2; c.memToReg = 2'd2; c.regWrite = 1'b1;
            end
            seqQ.push_back(c);
         end
         CL_JR: begin
            c = '0; c.pcSrc = 2'd3; c.pcEn = 1'b1; c.done = 1'b1; seqQ.push_back(c);
         end
         default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            for (int i = 0; i < TRAP_HOLD; i++) begin
               c = '0; c.illegal = 1'b1; seqQ.push_back(c);
            end
`endif
         end
      endcase
   endtask

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int ix, input ctl_t c);
      if (ix == 0) exp_q0.push_back(c);
      else         exp_q1.push_back(c);
   endtask

   task automatic drive(input int ix, input logic rstv, input logic setOp,
                        input logic [5:0] op, input logic [5:0] funct, input logic z);
      if (ix == 0) begin
         rst0 = rstv; zero0 = z;
         if (setOp) begin op0 = op; funct0 = funct; end
      end else begin
         rst1 = rstv; zero1 = z;
         if (setOp) begin op1 = op; funct1 = funct; end
      end
   endtask

   task automatic do_reset(input int ix, input int n);
      for (int i = 0; i < n; i++) begin
         drive(ix, 1'b0, 1'b0, 6'h00, 6'h00, 1'($urandom));
         push_exp(ix, '0);
         next_cycle();
      end
   endtask

   // Runs one instruction; abortAt >= 0 asserts reset in that cycle of the instruction.
   task automatic run_instr(input int ix, input logic [5:0] op, input logic [5:0] funct,
                            input logic z, input int abortAt);
      int lat;
      int n;
      lat = (ix == 0) ? LAT0 : LAT1;
      build_seq(lat, op, funct, z);
      if (abortAt >= 0) begin
         while (seqQ.size() > abortAt) void'(seqQ.pop_back());
         seqQ.push_back('0);
      end
      n = seqQ.size();
      foreach (seqQ[i]) push_exp(ix, seqQ[i]);
      for (int i = 0; i < n; i++) begin
         drive(ix, (abortAt >= 0 && i == abortAt) ? 1'b0 : 1'b1, (i == lat), op, funct,
               (i == lat + 1) ? z : 1'($urandom));
         next_cycle();
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      if (abortAt < 0 && classOf(op, funct) == CL_BAD) do_reset(ix, 1);
`endif
   endtask

   task automatic random_instr(output logic [5:0] op, output logic [5:0] funct);
      int k;
      k     = $urandom_range(0, 12);
      funct = 6'($urandom);
      op    = 6'h00;
      case (k)
         0:  if (funct == 6'h08) funct = 6'h20;
         1:  funct = 6'h08;
         2:  op = 6'h02;
         3:  op = 6'h03;
         4:  op = 6'h04;
         5:  op = 6'h05;
         6:  op = 6'h08;
         7:  op = 6'h0C;
         8:  op = 6'h0D;
         9:  op = 6'h0F;
         10: op = 6'h23;
         11: op = 6'h2B;
         default: begin
            op = 6'h3F;
            while (classOf(op, funct) != CL_BAD) op = 6'($urandom);
         end
      endcase
   endtask

   // ---------------- scoreboard / monitor ----------------
   task automatic check(input int ix, input logic [W-1:0] expv, input logic [W-1:0] got);
      tests++;
      if (got !== expv) begin
         failed++;
         $display("FAIL ctl_L%0d cycle %0d: got %h required %h", (ix == 0) ? LAT0 : LAT1,
                  cyc, got, expv);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q0.size() > 0) check(0, exp_q0.pop_front(), obs0);
      if (exp_q1.size() > 0) check(1, exp_q1.pop_front(), obs1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [12:0] d;
      logic [5:0]  rop;
      logic [5:0]  rfn;
      tests  = 0;
      failed = 0;
      cyc    = 0;
      rst0 = 1'b0; zero0 = 1'b0; op0 = 6'h00; funct0 = 6'h00;
      rst1 = 1'b0; zero1 = 1'b0; op1 = 6'h00; funct1 = 6'h00;
      next_cycle();
      for (int ix = 0; ix < 2; ix++) begin
         do_reset(ix, 3);
         for (int i = 0; i < 16; i++) begin
            d = DIRECTED[i];
            run_instr(ix, d[12:7], d[6:1], d[0], -1);
         end
         for (int i = 0; i < 40; i++) begin
            random_instr(rop, rfn);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            if (classOf(rop, rfn) == CL_BAD) rop = 6'h23;
`endif
            run_instr(ix, rop, rfn, 1'($urandom), -1);
         end
         if (ix == 1) begin
            // sw aborted by reset in its second MEM_WR cycle, then a normal add
            run_instr(ix, 6'h2B, 6'h00, 1'b0, LAT1 + 3);
            run_instr(ix, 6'h00, 6'h20, 1'b0, -1);
         end
         drive(ix, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0);
      end
      next_cycle();
      next_cycle();
      tests++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         failed++;
         $display("FAIL drain: got %0d/%0d entries left required 0/0", exp_q0.size(),
                  exp_q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
